// File: rtl/pe_arr_drain.sv
// pe_arr_drain: result-side reader for the systolic PE array.
// Snapshots each PE's accumulator into a shadow buffer as its valid rises,
// then streams the whole tile out row-major, one word per beat, over a
// valid/ready interface. The array is free for the next tile as soon as the
// snapshot is complete.
//
// Build option: define PE_DRAIN_SAT_EN to saturate each signed OUTWIDTH result
// into the signed DWIDTH range; otherwise results are truncated to the low
// DWIDTH bits.
//
//  state      | meaning
//  -----------+--------------------------------------------------------------
//  ST_COLLECT | capture results into the buffer until every PE has reported
//  ST_STREAM  | stream buffer[ptr] downstream, one beat per accepted transfer

module pe_arr_drain #(
   parameter int ROWS     = 8,
   parameter int COLS     = 8,
   parameter int OUTWIDTH = 32,
   parameter int DWIDTH   = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [ROWS*COLS*OUTWIDTH-1:0]     res_in,
   input  logic [ROWS*COLS-1:0]              res_valid,
   output logic [DWIDTH-1:0]                 out_data,
   output logic [$clog2(ROWS*COLS)-1:0]      out_idx,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic                              out_last,
   output logic                              busy,
   output logic                              tile_done,
   output logic                              overrun
);

   localparam int NPE = ROWS * COLS;
   localparam int IW  = $clog2(NPE);
   localparam logic [IW-1:0] LAST_IDX = IW'(NPE - 1);

`ifdef PE_DRAIN_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_STREAM  = 1'b1
   } state_t;

   state_t              state;
   logic [NPE-1:0]      mask;
   logic [IW-1:0]       ptr;
   logic [OUTWIDTH-1:0] res_buf [NPE];

   logic [NPE-1:0]      cap_en;
   logic [NPE-1:0]      mask_nxt;
   logic [IW-1:0]       ptr_inc;
   logic [OUTWIDTH-1:0] word0_nxt;
   logic                xfer;

   // Narrow a signed result to the output word. The upper bits from the
   // output sign bit upward must all agree for the value to fit; if they do
   // not, clamp toward the sign of the original value.
   function automatic logic [DWIDTH-1:0] conv(input logic [OUTWIDTH-1:0] v);
      logic [OUTWIDTH-DWIDTH:0] hi;
      logic                     fits;
      hi   = v[OUTWIDTH-1:DWIDTH-1];
      fits = (&hi) | (~|hi);
      if (SAT_EN && !fits) begin
         if (v[OUTWIDTH-1]) conv = {1'b1, {(DWIDTH-1){1'b0}}};
         else               conv = {1'b0, {(DWIDTH-1){1'b1}}};
      end else begin
         conv = v[DWIDTH-1:0];
      end
   endfunction

   // Capture enables: only in COLLECT, only for PEs not yet captured this tile.
   always_comb begin
      cap_en = '0;
      if (state == ST_COLLECT) cap_en = res_valid & ~mask;
   end

   assign mask_nxt  = mask | cap_en;
   assign ptr_inc   = ptr + 1'b1;
   assign xfer      = out_valid & out_ready;
   // PE0 may be captured on the same edge that completes the snapshot, so
   // the first beat has to see the incoming value rather than the stale one.
   assign word0_nxt = cap_en[0] ? res_in[0 +: OUTWIDTH] : res_buf[0];
   assign out_idx   = ptr;

   // Shadow buffer: written once per PE per tile, contents need no reset.
   always_ff @(posedge clk) begin
      for (int k = 0; k < NPE; k++) begin
         if (cap_en[k]) res_buf[k] <= res_in[k*OUTWIDTH +: OUTWIDTH];
      end
   end

   // Collect/stream sequencing with registered stream outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_COLLECT;
         mask      <= '0;
         ptr       <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         tile_done <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         tile_done <= 1'b0;
         case (state)
            ST_COLLECT: begin
               if (|(res_valid & mask)) overrun <= 1'b1;
               if (&mask_nxt) begin
                  state     <= ST_STREAM;
                  mask      <= '0;
                  ptr       <= '0;
                  out_data  <= conv(word0_nxt);
                  out_valid <= 1'b1;
                  out_last  <= (LAST_IDX == '0);
                  busy      <= 1'b1;
               end else begin
                  mask <= mask_nxt;
               end
            end
            ST_STREAM: begin
               // The snapshot is frozen while streaming; late results are lost.
               if (|res_valid) overrun <= 1'b1;
               if (xfer) begin
                  if (out_last) begin
                     state     <= ST_COLLECT;
                     ptr       <= '0;
                     out_data  <= '0;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     busy      <= 1'b0;
                     tile_done <= 1'b1;
                  end else begin
                     ptr      <= ptr_inc;
                     out_data <= conv(res_buf[ptr_inc]);
                     out_last <= (ptr_inc == LAST_IDX);
                  end
               end
            end
            default: state <= ST_COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_pe_arr_drain.sv
// Bench for pe_arr_drain: a 2x2 instance for the directed scenarios and a
// default 8x8 instance for back-to-back full tiles. Expected beats are queued
// when results are driven and checked as the DUT transfers them.

module tb_pe_arr_drain;

   typedef struct packed {
      logic [15:0] data;
      logic [5:0]  idx;
      logic        last;
   } beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1;

   logic [127:0] s_res_in    = '0;
   logic [3:0]   s_res_valid = '0;
   logic [15:0]  s_out_data;
   logic [1:0]   s_out_idx;
   logic         s_out_valid, s_out_last, s_busy, s_tile_done, s_overrun;
   logic         s_out_ready = 1'b0;

   logic [2047:0] b_res_in    = '0;
   logic [63:0]   b_res_valid = '0;
   logic [15:0]   b_out_data;
   logic [5:0]    b_out_idx;
   logic          b_out_valid, b_out_last, b_busy, b_tile_done, b_overrun;
   logic          b_out_ready = 1'b1;

   int vectors = 0;
   int miscompares = 0;

   beat_t s_q[$];
   beat_t b_q[$];
   int s_xfers = 0, b_xfers = 0, s_dones = 0, b_dones = 0;

   pe_arr_drain #(.ROWS(2), .COLS(2), .OUTWIDTH(32), .DWIDTH(16)) dut_s (
      .clk(clk), .rst(rst), .res_in(s_res_in), .res_valid(s_res_valid),
      .out_data(s_out_data), .out_idx(s_out_idx), .out_valid(s_out_valid),
      .out_ready(s_out_ready), .out_last(s_out_last), .busy(s_busy),
      .tile_done(s_tile_done), .overrun(s_overrun)
   );

   pe_arr_drain dut_b (
      .clk(clk), .rst(rst), .res_in(b_res_in), .res_valid(b_res_valid),
      .out_data(b_out_data), .out_idx(b_out_idx), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_last(b_out_last), .busy(b_busy),
      .tile_done(b_tile_done), .overrun(b_overrun)
   );

   function automatic logic [15:0] exp_conv(input logic [31:0] v);
`ifdef PE_DRAIN_SAT_EN
      if ($signed(v) > 32'sd32767)  return 16'h7fff;
      if ($signed(v) < -32'sd32768) return 16'h8000;
`endif
      return v[15:0];
   endfunction

   function automatic beat_t mk(input logic [15:0] d, input int i, input logic l);
      beat_t b;
      b.data = d;
      b.idx  = 6'(i);
      b.last = l;
      return b;
   endfunction

   // Small-instance monitor: beat scoreboard, stall stability, tile_done timing.
   logic        s_prev_stall = 1'b0, s_prev_lastx = 1'b0;
   logic [15:0] s_h_data;
   logic [1:0]  s_h_idx;
   logic        s_h_last;
   always @(negedge clk) begin
      beat_t e;
      if (rst) begin
         s_prev_stall = 1'b0;
         s_prev_lastx = 1'b0;
      end else begin
         vectors++;
         if (s_tile_done !== s_prev_lastx || (s_prev_lastx && s_out_valid !== 1'b0)) begin
            miscompares++;
            $display("FAIL s_tile_done_timing: got done=%b valid=%b expected done=%b valid=0",
                     s_tile_done, s_out_valid, s_prev_lastx);
         end
         if (s_tile_done === 1'b1) s_dones++;
         if (s_prev_stall) begin
            vectors++;
            if ({s_out_valid, s_out_data, s_out_idx, s_out_last} !== {1'b1, s_h_data, s_h_idx, s_h_last}) begin
               miscompares++;
               $display("FAIL s_stall_hold: got v=%b d=%h i=%0d l=%b expected v=1 d=%h i=%0d l=%b",
                        s_out_valid, s_out_data, s_out_idx, s_out_last, s_h_data, s_h_idx, s_h_last);
            end
         end
         if (s_out_valid === 1'b1 && s_out_ready === 1'b1) begin
            vectors++;
            if (s_q.size() == 0) begin
               miscompares++;
               $display("FAIL s_beat_unexpected: got d=%h i=%0d expected no beat", s_out_data, s_out_idx);
            end else begin
               e = s_q.pop_front();
               if ({s_out_data, s_out_idx, s_out_last} !== {e.data, e.idx[1:0], e.last}) begin
                  miscompares++;
                  $display("FAIL s_beat: got d=%h i=%0d l=%b expected d=%h i=%0d l=%b",
                           s_out_data, s_out_idx, s_out_last, e.data, e.idx, e.last);
               end
            end
            s_xfers++;
         end
         s_prev_stall = (s_out_valid === 1'b1) && (s_out_ready !== 1'b1);
         s_h_data = s_out_data;
         s_h_idx  = s_out_idx;
         s_h_last = s_out_last;
         s_prev_lastx = (s_out_valid === 1'b1) && (s_out_ready === 1'b1) && (s_out_last === 1'b1);
      end
   end

   // Large-instance monitor: beat scoreboard and tile_done timing.
   logic b_prev_lastx = 1'b0;
   always @(negedge clk) begin
      beat_t e;
      if (rst) begin
         b_prev_lastx = 1'b0;
      end else begin
         if (b_tile_done !== b_prev_lastx) begin
            vectors++;
            miscompares++;
            $display("FAIL b_tile_done_timing: got %b expected %b", b_tile_done, b_prev_lastx);
         end
         if (b_tile_done === 1'b1) b_dones++;
         if (b_out_valid === 1'b1 && b_out_ready === 1'b1) begin
            vectors++;
            if (b_q.size() == 0) begin
               miscompares++;
               $display("FAIL b_beat_unexpected: got d=%h i=%0d", b_out_data, b_out_idx);
            end else begin
               e = b_q.pop_front();
               if ({b_out_data, b_out_idx, b_out_last} !== {e.data, e.idx, e.last}) begin
                  miscompares++;
                  $display("FAIL b_beat: got d=%h i=%0d l=%b expected d=%h i=%0d l=%b",
                           b_out_data, b_out_idx, b_out_last, e.data, e.idx, e.last);
               end
            end
            b_xfers++;
         end
         b_prev_lastx = (b_out_valid === 1'b1) && (b_out_ready === 1'b1) && (b_out_last === 1'b1);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic s_capture(input logic [3:0] vm, input logic [31:0] v0, v1, v2, v3);
      s_res_in    = {v3, v2, v1, v0};
      s_res_valid = vm;
      cyc();
      s_res_valid = '0;
   endtask

   task automatic s_expect(input logic [31:0] v0, v1, v2, v3);
      s_q.push_back(mk(exp_conv(v0), 0, 1'b0));
      s_q.push_back(mk(exp_conv(v1), 1, 1'b0));
      s_q.push_back(mk(exp_conv(v2), 2, 1'b0));
      s_q.push_back(mk(exp_conv(v3), 3, 1'b1));
   endtask

   task automatic s_wait_drain(input string tag);
      int n = 0;
      while ((s_q.size() != 0 || s_out_valid !== 1'b0 || s_tile_done !== 1'b0) && n < 50) begin
         cyc();
         n++;
      end
      vectors++;
      if (n >= 50) begin
         miscompares++;
         $display("FAIL %s_drain_timeout: got %0d beats pending expected 0", tag, s_q.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc();
      cyc();
      vectors++;
      if ({s_out_valid, s_out_last, s_out_idx, s_out_data, s_busy, s_tile_done, s_overrun} !== '0) begin
         miscompares++;
         $display("FAIL s_reset_outputs: got v=%b l=%b i=%0d d=%h busy=%b done=%b ovr=%b expected all 0",
                  s_out_valid, s_out_last, s_out_idx, s_out_data, s_busy, s_tile_done, s_overrun);
      end
      vectors++;
      if ({b_out_valid, b_out_last, b_out_idx, b_out_data, b_busy, b_tile_done, b_overrun} !== '0) begin
         miscompares++;
         $display("FAIL b_reset_outputs: got v=%b i=%0d d=%h busy=%b expected all 0",
                  b_out_valid, b_out_idx, b_out_data, b_busy);
      end
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_staggered();
      int x0, d0;
      s_out_ready = 1'b1;
      s_expect(10, 20, 30, 40);
      s_capture(4'b0001, 10, 0, 0, 0);
      s_capture(4'b0010, 0, 20, 0, 0);
      s_capture(4'b0100, 0, 0, 30, 0);
      vectors++;
      if (s_out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL stag_early_valid: got %b expected 0", s_out_valid);
      end
      s_capture(4'b1000, 0, 0, 0, 40);
      vectors++;
      if ({s_out_valid, s_busy, s_out_idx} !== {1'b1, 1'b1, 2'd0}) begin
         miscompares++;
         $display("FAIL stag_first_beat_latency: got v=%b busy=%b i=%0d expected v=1 busy=1 i=0",
                  s_out_valid, s_busy, s_out_idx);
      end
      x0 = s_xfers;
      d0 = s_dones;
      repeat (4) cyc();
      vectors++;
      if (s_xfers - x0 != 4 || s_tile_done !== 1'b1) begin
         miscompares++;
         $display("FAIL stag_drain_cycles: got %0d beats done=%b expected 4 beats done=1",
                  s_xfers - x0, s_tile_done);
      end
      s_wait_drain("stag");
      vectors++;
      if (s_dones - d0 != 1 || s_overrun !== 1'b0) begin
         miscompares++;
         $display("FAIL stag_done_overrun: got dones=%0d ovr=%b expected dones=1 ovr=0",
                  s_dones - d0, s_overrun);
      end
   endtask

   task automatic test_backpressure();
      logic [6:0] pat = 7'b1110010;
      int x0;
      s_out_ready = 1'b0;
      s_expect(1, 2, 3, 4);
      s_capture(4'b1111, 1, 2, 3, 4);
      x0 = s_xfers;
      for (int i = 0; i < 7; i++) begin
         s_out_ready = pat[i];
         cyc();
      end
      vectors++;
      if (s_xfers - x0 != 4) begin
         miscompares++;
         $display("FAIL bp_transfer_count: got %0d expected 4", s_xfers - x0);
      end
      s_wait_drain("bp");
   endtask

   task automatic test_saturation();
      s_out_ready = 1'b1;
`ifdef PE_DRAIN_SAT_EN
      s_q.push_back(mk(16'h7fff, 0, 1'b0));
      s_q.push_back(mk(16'h8000, 1, 1'b0));
`else
      s_q.push_back(mk(16'h2345, 0, 1'b0));
      s_q.push_back(mk(16'h0000, 1, 1'b0));
`endif
      s_q.push_back(mk(16'h7fff, 2, 1'b0));
      s_q.push_back(mk(16'hfffe, 3, 1'b1));
      s_capture(4'b1111, 32'h0001_2345, 32'hffff_0000, 32'h0000_7fff, 32'hffff_fffe);
      s_wait_drain("sat");
   endtask

   task automatic test_overrun();
      s_out_ready = 1'b1;
      s_expect(5, 6, 7, 8);
      s_capture(4'b0001, 5, 0, 0, 0);
      vectors++;
      if (s_overrun !== 1'b0) begin
         miscompares++;
         $display("FAIL ovr_first_capture: got %b expected 0", s_overrun);
      end
      s_capture(4'b0001, 9, 0, 0, 0);
      vectors++;
      if (s_overrun !== 1'b1) begin
         miscompares++;
         $display("FAIL ovr_repeat_valid: got %b expected 1", s_overrun);
      end
      s_capture(4'b1110, 0, 6, 7, 8);
      s_wait_drain("ovr");
      // Next tile: a result arriving mid-stream must not disturb the snapshot.
      s_out_ready = 1'b0;
      s_expect(21, 22, 23, 24);
      s_capture(4'b1111, 21, 22, 23, 24);
      s_capture(4'b0100, 0, 0, 99, 0);
      s_out_ready = 1'b1;
      s_wait_drain("ovr2");
      vectors++;
      if (s_overrun !== 1'b1) begin
         miscompares++;
         $display("FAIL ovr_sticky: got %b expected 1", s_overrun);
      end
   endtask

   task automatic test_reset_midstream();
      int x0, n = 0, d0;
      s_out_ready = 1'b1;
      s_expect(31, 32, 33, 34);
      x0 = s_xfers;
      s_capture(4'b1111, 31, 32, 33, 34);
      while (s_xfers - x0 < 2 && n < 10) begin
         cyc();
         n++;
      end
      vectors++;
      if (s_xfers - x0 != 2) begin
         miscompares++;
         $display("FAIL rst_mid_two_beats: got %0d expected 2", s_xfers - x0);
      end
      d0 = s_dones;
      rst = 1'b1;
      s_out_ready = 1'b0;
      cyc();
      vectors++;
      if ({s_out_valid, s_busy, s_tile_done, s_overrun} !== 4'b0000) begin
         miscompares++;
         $display("FAIL rst_mid_abort: got v=%b busy=%b done=%b ovr=%b expected all 0",
                  s_out_valid, s_busy, s_tile_done, s_overrun);
      end
      rst = 1'b0;
      s_q.delete();
      cyc();
      vectors++;
      if (s_tile_done !== 1'b0 || s_dones != d0) begin
         miscompares++;
         $display("FAIL rst_mid_no_done: got done=%b count=%0d expected 0", s_tile_done, s_dones - d0);
      end
      s_out_ready = 1'b1;
      s_expect(11, 12, 13, 14);
      s_capture(4'b1111, 11, 12, 13, 14);
      s_wait_drain("rst_fresh");
   endtask

   task automatic b_run_tile(input int tile, input string tag);
      logic [31:0] v;
      int x0, n = 0;
      for (int k = 0; k < 64; k++) begin
         if (tile == 0) v = 32'(k * 1000 - 20000);
         else           v = (32'(k) << 16) | 32'(k * 7);
         b_res_in[k*32 +: 32] = v;
         b_q.push_back(mk(exp_conv(v), k, k == 63));
      end
      x0 = b_xfers;
      b_res_valid = '1;
      cyc();
      b_res_valid = '0;
      while (b_tile_done !== 1'b1 && n < 100) begin
         cyc();
         n++;
      end
      vectors++;
      if (n != 64 || b_xfers - x0 != 64) begin
         miscompares++;
         $display("FAIL %s_drain: got %0d cycles %0d beats expected 64 cycles 64 beats",
                  tag, n, b_xfers - x0);
      end
   endtask

   task automatic test_back_to_back();
      int d0 = b_dones;
      b_out_ready = 1'b1;
      b_run_tile(0, "b2b_tile0");
      b_run_tile(1, "b2b_tile1");
      cyc();
      cyc();
      vectors++;
      if (b_dones - d0 != 2 || b_overrun !== 1'b0 || b_q.size() != 0) begin
         miscompares++;
         $display("FAIL b2b_summary: got dones=%0d ovr=%b pending=%0d expected dones=2 ovr=0 pending=0",
                  b_dones - d0, b_overrun, b_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_staggered();
      test_backpressure();
      test_saturation();
      test_overrun();
      test_reset_midstream();
      test_back_to_back();
      vectors++;
      if (s_q.size() != 0) begin
         miscompares++;
         $display("FAIL s_queue_empty: got %0d pending expected 0", s_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
